// File: rtl/amo_pkg.sv
// Shared encodings for the RV64A atomic sequencer: op codes, size codes,
// FSM states and the one-hot ALU result-select bit positions.
package amo_pkg;

  typedef enum logic [3:0] {
    OP_SWAP = 4'd0,
    OP_ADD  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_MAX  = 4'd5,
    OP_MIN  = 4'd6,
    OP_MAXU = 4'd7,
    OP_MINU = 4'd8,
    OP_LR   = 4'd9,
    OP_SC   = 4'd10
  } amo_op_e;

  localparam logic [3:0] SZ_W = 4'b0100;
  localparam logic [3:0] SZ_D = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_RD,
    S_CALC,
    S_WR,
    S_DONE,
    S_FAULT
  } state_e;

  localparam int SEL_DS1 = 0;
  localparam int SEL_DS2 = 1;
  localparam int SEL_ADD = 2;
  localparam int SEL_AND = 3;
  localparam int SEL_OR  = 4;
  localparam int SEL_XOR = 5;
  localparam int SEL_MAX = 6;
  localparam int SEL_MIN = 7;

  function automatic logic [7:0] op_sel(input logic [3:0] op);
    logic [7:0] s;
    s = '0;
    case (op)
      OP_SWAP:          s[SEL_DS2] = 1'b1;
      OP_ADD:           s[SEL_ADD] = 1'b1;
      OP_AND:           s[SEL_AND] = 1'b1;
      OP_OR:            s[SEL_OR]  = 1'b1;
      OP_XOR:           s[SEL_XOR] = 1'b1;
      OP_MAX, OP_MAXU:  s[SEL_MAX] = 1'b1;
      OP_MIN, OP_MINU:  s[SEL_MIN] = 1'b1;
      default:          s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/amo_rsv.sv
// LR/SC reservation: one granule + size, set by LR, cleared by snoops, faults,
// flushes, SC checks and AMO writes to the same granule. Match is combinational.
module amo_rsv #(
  parameter int XLEN     = 64,
  parameter int RSV_GRAN = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set,
  input  logic                     clr,
  input  logic                     amo_wr,
  input  logic [XLEN-RSV_GRAN-1:0] gran,
  input  logic [3:0]               size,
  input  logic                     snoop_inv,
  input  logic [XLEN-RSV_GRAN-1:0] snoop_gran,
  output logic                     match
);

  logic                     valid;
  logic [XLEN-RSV_GRAN-1:0] gran_q;
  logic [3:0]               size_q;
  logic                     gran_hit;
  logic                     snoop_hit;

  assign gran_hit  = valid && (gran == gran_q);
  assign snoop_hit = valid && snoop_inv && (snoop_gran == gran_q);
  // A snoop landing in the SC check cycle must make that SC fail.
  assign match     = gran_hit && (size == size_q) && !snoop_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      gran_q <= '0;
      size_q <= '0;
    end else if (set) begin
      valid  <= !(snoop_inv && (snoop_gran == gran));
      gran_q <= gran;
      size_q <= size;
    end else if (clr || snoop_hit || (amo_wr && gran_hit)) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/amo_sequencer.sv
// EX-stage RV64A sequencer: CHK -> RD -> CALC -> WR -> DONE for AMOs (5 cycles
// to done at zero-wait), LR/SC short paths; waits on mem_ack for every request.
module amo_sequencer #(
  parameter int XLEN     = 64,
  parameter int RSV_GRAN = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            amo_valid,
  input  logic [3:0]      amo_op,
  input  logic [3:0]      amo_size,
  input  logic [XLEN-1:0] amo_addr,
  input  logic [XLEN-1:0] amo_rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            fault,
  output logic [XLEN-1:0] rd_data,
  output logic            mem_req,
  output logic            mem_wr,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_size,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic            mem_err,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] alu_ds1,
  output logic [XLEN-1:0] alu_ds2,
  output logic [7:0]      alu_sel,
  output logic            alu_unsign,
  input  logic [XLEN-1:0] alu_result,
  input  logic            snoop_inv,
  input  logic [XLEN-1:0] snoop_addr
);
  import amo_pkg::*;

  state_e          st, nxt;
  logic [3:0]      op_q, size_q;
  logic [XLEN-1:0] addr_q, rs2_q, ld_q;
  logic            flushed_q, done_r;
  logic            legal, aligned, is_amo, flush_eff, is_req;
  logic            rsv_set, rsv_clr, rsv_amo_wr, rsv_match;
  logic [XLEN-1:0] rdata_ext;

  function automatic logic [XLEN-1:0] sext_w(input logic [3:0] sz, input logic [XLEN-1:0] d);
    if (sz == SZ_W) return {{(XLEN-32){d[31]}}, d[31:0]};
    return d;
  endfunction

  function automatic logic [XLEN-1:0] wfmt(input logic [3:0] sz, input logic [XLEN-1:0] d);
    if (sz == SZ_W) return {{(XLEN-32){1'b0}}, d[31:0]};
    return d;
  endfunction

  assign rdata_ext = sext_w(size_q, mem_rdata);
  assign legal     = (op_q <= OP_SC) && ((size_q == SZ_W) || (size_q == SZ_D));
  assign aligned   = (size_q == SZ_D) ? (addr_q[2:0] == 3'b000) : (addr_q[1:0] == 2'b00);
  assign is_amo    = (op_q < OP_LR);
  assign flush_eff = flush || flushed_q;
  assign is_req    = (nxt == S_RD) || (nxt == S_WR);

  always_comb begin
    nxt = st;
    case (st)
      S_IDLE:  if (amo_valid && !flush) nxt = S_CHK;
      S_CHK: begin
        if (flush)                   nxt = S_IDLE;
        else if (!legal || !aligned) nxt = S_FAULT;
        else if (op_q == OP_SC)      nxt = rsv_match ? S_WR : S_DONE;
        else                         nxt = S_RD;
      end
      S_RD: if (mem_ack) begin
        if (flush_eff)          nxt = S_IDLE;
        else if (mem_err)       nxt = S_FAULT;
        else if (op_q == OP_LR) nxt = S_DONE;
        else                    nxt = S_CALC;
      end
      S_CALC:  nxt = flush ? S_IDLE : S_WR;
      S_WR: if (mem_ack) begin
        if (flush_eff)    nxt = S_IDLE;
        else if (mem_err) nxt = S_FAULT;
        else              nxt = S_DONE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign rsv_set    = (st == S_RD) && mem_ack && !mem_err && !flush_eff && (op_q == OP_LR);
  assign rsv_clr    = ((nxt == S_FAULT) && (st != S_FAULT)) ||
                      ((st == S_IDLE) && flush) ||
                      ((st == S_CHK) && (op_q == OP_SC) && !flush);
  assign rsv_amo_wr = (st == S_WR) && mem_ack && is_amo;

  amo_rsv #(.XLEN(XLEN), .RSV_GRAN(RSV_GRAN)) u_rsv (
    .clk        (clk),
    .rst_n      (rst_n),
    .set        (rsv_set),
    .clr        (rsv_clr),
    .amo_wr     (rsv_amo_wr),
    .gran       (addr_q[XLEN-1:RSV_GRAN]),
    .size       (size_q),
    .snoop_inv  (snoop_inv),
    .snoop_gran (snoop_addr[XLEN-1:RSV_GRAN]),
    .match      (rsv_match)
  );

  // A completion already registered is still suppressed if the op is killed in DONE.
  assign done = done_r && !(flush && (st == S_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      op_q       <= '0;
      size_q     <= '0;
      addr_q     <= '0;
      rs2_q      <= '0;
      ld_q       <= '0;
      flushed_q  <= 1'b0;
      busy       <= 1'b0;
      done_r     <= 1'b0;
      fault      <= 1'b0;
      rd_data    <= '0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_size   <= '0;
      mem_wdata  <= '0;
      alu_ds1    <= '0;
      alu_ds2    <= '0;
      alu_sel    <= '0;
      alu_unsign <= 1'b0;
    end else begin
      st <= nxt;
      if ((st == S_IDLE) && amo_valid && !flush) begin
        op_q   <= amo_op;
        size_q <= amo_size;
        addr_q <= amo_addr;
        rs2_q  <= amo_rs2;
      end
      if ((st == S_RD) && mem_ack) ld_q <= rdata_ext;
      // A flush seen mid-request is remembered until the memory side acks.
      flushed_q <= ((st == S_RD) || (st == S_WR)) && flush_eff && !mem_ack;

      busy     <= (nxt != S_IDLE);
      mem_req  <= is_req;
      mem_wr   <= (nxt == S_WR);
      mem_addr <= is_req ? addr_q : '0;
      mem_size <= is_req ? size_q : '0;
      if (nxt != S_WR)
        mem_wdata <= '0;
      else if (st != S_WR)
        mem_wdata <= wfmt(size_q, (st == S_CALC) ? alu_result : rs2_q);

      alu_sel    <= (nxt == S_CALC) ? op_sel(op_q) : 8'h00;
      alu_unsign <= (nxt == S_CALC) && ((op_q == OP_MAXU) || (op_q == OP_MINU));
      alu_ds1    <= (nxt == S_CALC) ? rdata_ext : '0;
      alu_ds2    <= (nxt == S_CALC) ? sext_w(size_q, rs2_q) : '0;

      done_r <= (nxt == S_DONE) || (nxt == S_FAULT);
      fault  <= (nxt == S_FAULT);
      if (nxt == S_DONE) begin
        case (st)
          S_RD:    rd_data <= rdata_ext;
          S_CHK:   rd_data <= {{(XLEN-1){1'b0}}, 1'b1};
          S_WR:    rd_data <= (op_q == OP_SC) ? '0 : ld_q;
          default: rd_data <= '0;
        endcase
      end else begin
        rd_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_amo_sequencer.sv
// Directed vector bench for amo_sequencer with a memory responder and ALU model.
module tb_amo_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        amo_valid = 1'b0;
  logic [3:0]  amo_op = '0, amo_size = '0;
  logic [63:0] amo_addr = '0, amo_rs2 = '0;
  logic        flush = 1'b0;
  logic        busy, done, fault, mem_req, mem_wr, alu_unsign;
  logic [63:0] rd_data, mem_addr, mem_wdata, alu_ds1, alu_ds2;
  logic [3:0]  mem_size;
  logic [7:0]  alu_sel;
  logic        mem_ack = 1'b0, mem_err = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic [63:0] alu_result;
  logic        snoop_inv = 1'b0;
  logic [63:0] snoop_addr = '0;

  logic [63:0] mem_val = '0;
  logic        rd_err = 1'b0;
  int          ack_dly = 0;
  int          wait_cnt = 0;
  int          n_vec = 0, n_bad = 0, n_cmp = 0;

  always #5 clk = ~clk;

  amo_sequencer #(.XLEN(64), .RSV_GRAN(6)) dut (
    .clk(clk), .rst_n(rst_n), .amo_valid(amo_valid), .amo_op(amo_op),
    .amo_size(amo_size), .amo_addr(amo_addr), .amo_rs2(amo_rs2), .flush(flush),
    .busy(busy), .done(done), .fault(fault), .rd_data(rd_data),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .alu_ds1(alu_ds1), .alu_ds2(alu_ds2), .alu_sel(alu_sel), .alu_unsign(alu_unsign),
    .alu_result(alu_result), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr)
  );

  always_comb begin
    logic lt;
    lt = alu_unsign ? (alu_ds1 < alu_ds2) : ($signed(alu_ds1) < $signed(alu_ds2));
    alu_result = '0;
    if (alu_sel[0])      alu_result = alu_ds1;
    else if (alu_sel[1]) alu_result = alu_ds2;
    else if (alu_sel[2]) alu_result = alu_ds1 + alu_ds2;
    else if (alu_sel[3]) alu_result = alu_ds1 & alu_ds2;
    else if (alu_sel[4]) alu_result = alu_ds1 | alu_ds2;
    else if (alu_sel[5]) alu_result = alu_ds1 ^ alu_ds2;
    else if (alu_sel[6]) alu_result = lt ? alu_ds2 : alu_ds1;
    else if (alu_sel[7]) alu_result = lt ? alu_ds1 : alu_ds2;
  end

  // Memory responder: ack after ack_dly waiting cycles of a held request.
  always @(negedge clk) begin
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    if (mem_req) begin
      if (wait_cnt >= ack_dly) begin
        mem_ack = 1'b1; mem_err = rd_err && !mem_wr; mem_rdata = mem_val; wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  typedef struct {
    logic [3:0]  op, size;
    logic [63:0] addr, rs2, mval;
    logic        err;
    logic [63:0] rd;
    logic        flt, rdreq, wr;
    logic [63:0] wdata;
    logic [7:0]  sel;
    logic        uns;
    int          lat;
  } vec_t;

  vec_t vt[19];

  function automatic vec_t mk(logic [3:0] op, logic [3:0] sz, logic [63:0] ad, logic [63:0] r2,
                              logic [63:0] mv, logic er, logic [63:0] rd, logic fl, logic rq,
                              logic wr, logic [63:0] wd, logic [7:0] sl, logic un, int lt);
    vec_t v;
    v.op = op; v.size = sz; v.addr = ad; v.rs2 = r2; v.mval = mv; v.err = er; v.rd = rd;
    v.flt = fl; v.rdreq = rq; v.wr = wr; v.wdata = wd; v.sel = sl; v.uns = un; v.lat = lt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
      n_bad++;
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [3:0] sz, input logic [63:0] ad,
                        input logic [63:0] r2, input int flush_at, input bit snoop_chk,
                        input int budget, output int lat, output logic [63:0] rd,
                        output logic flt, output logic rdreq, output logic [63:0] raddr,
                        output logic wr, output logic [63:0] wd, output logic [7:0] sel,
                        output logic uns, output int req_cyc);
    int w;
    lat = -1; rd = '0; flt = 0; rdreq = 0; raddr = '0; wr = 0; wd = '0; sel = '0; uns = 0;
    req_cyc = 0; w = 0;
    @(negedge clk);
    while (busy && w < 50) begin @(negedge clk); w++; end
    amo_valid = 1'b1; amo_op = op; amo_size = sz; amo_addr = ad; amo_rs2 = r2;
    @(posedge clk); #1 amo_valid = 1'b0;
    if (snoop_chk) begin snoop_inv = 1'b1; snoop_addr = ad; end
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 2) snoop_inv = 1'b0;
      flush = (c == flush_at);
      if (mem_req) req_cyc++;
      if (mem_req && !mem_wr) begin rdreq = 1; raddr = mem_addr; end
      if (mem_req && mem_wr) begin wr = 1; wd = mem_wdata; end
      if (alu_sel != 8'h00) begin sel = alu_sel; uns = alu_unsign; end
      if (done) begin lat = c; rd = rd_data; flt = fault; break; end
    end
    flush = 1'b0; snoop_inv = 1'b0;
  endtask

  initial begin
    int lat, rq_cyc;
    logic [63:0] rd, raddr, wd, msk;
    logic flt, rq, wr, un;
    logic [7:0] sl;

    vt[0]  = mk(4'd1,  4'b1000, 64'h1000, 64'd3,  64'd5,                 0, 64'd5,                 0,1,1, 64'd8,  8'h04,0,5);
    vt[1]  = mk(4'd6,  4'b0100, 64'h1004, 64'd1,  64'hFFFF_FFFF,         0, 64'hFFFF_FFFF_FFFF_FFFF,0,1,1, 64'hFFFF_FFFF,8'h80,0,5);
    vt[2]  = mk(4'd8,  4'b0100, 64'h1004, 64'd1,  64'hFFFF_FFFF,         0, 64'hFFFF_FFFF_FFFF_FFFF,0,1,1, 64'd1,  8'h80,1,5);
    vt[3]  = mk(4'd0,  4'b1000, 64'h1008, 64'hAA, 64'h1234,              0, 64'h1234,              0,1,1, 64'hAA, 8'h02,0,5);
    vt[4]  = mk(4'd4,  4'b0100, 64'h100C, 64'hFF, 64'hF0,                0, 64'hF0,                0,1,1, 64'h0F, 8'h20,0,5);
    vt[5]  = mk(4'd7,  4'b1000, 64'h1010, 64'd1,  64'h8000_0000_0000_0000,0,64'h8000_0000_0000_0000,0,1,1, 64'h8000_0000_0000_0000,8'h40,1,5);
    vt[6]  = mk(4'd9,  4'b1000, 64'h2000, 64'd0,  64'h77,                0, 64'h77,                0,1,0, 64'd0,  8'h00,0,3);
    vt[7]  = mk(4'd10, 4'b1000, 64'h2008, 64'h99, 64'd0,                 0, 64'd0,                 0,0,1, 64'h99, 8'h00,0,3);
    vt[8]  = mk(4'd10, 4'b1000, 64'h2008, 64'h99, 64'd0,                 0, 64'd1,                 0,0,0, 64'd0,  8'h00,0,2);
    vt[9]  = mk(4'd0,  4'b0100, 64'h1002, 64'd7,  64'd0,                 0, 64'd0,                 1,0,0, 64'd0,  8'h00,0,2);
    vt[10] = mk(4'd3,  4'b1000, 64'h1018, 64'd7,  64'h55,                1, 64'd0,                 1,1,0, 64'd0,  8'h00,0,3);
    vt[11] = mk(4'd11, 4'b1000, 64'h1000, 64'd7,  64'd0,                 0, 64'd0,                 1,0,0, 64'd0,  8'h00,0,2);
    vt[12] = mk(4'd1,  4'b0010, 64'h1000, 64'd7,  64'd0,                 0, 64'd0,                 1,0,0, 64'd0,  8'h00,0,2);
    vt[13] = mk(4'd9,  4'b0100, 64'h3000, 64'd0,  64'h8000_0000,         0, 64'hFFFF_FFFF_8000_0000,0,1,0, 64'd0,  8'h00,0,3);
    vt[14] = mk(4'd9,  4'b1000, 64'h4000, 64'd0,  64'd1,                 0, 64'd1,                 0,1,0, 64'd0,  8'h00,0,3);
    vt[15] = mk(4'd2,  4'b1000, 64'h4010, 64'h3C, 64'hF0,                0, 64'hF0,                0,1,1, 64'h30, 8'h08,0,5);
    vt[16] = mk(4'd10, 4'b1000, 64'h4000, 64'd4,  64'd0,                 0, 64'd1,                 0,0,0, 64'd0,  8'h00,0,2);
    vt[17] = mk(4'd9,  4'b1000, 64'h5000, 64'd0,  64'd2,                 0, 64'd2,                 0,1,0, 64'd0,  8'h00,0,3);
    vt[18] = mk(4'd10, 4'b0100, 64'h5000, 64'd5,  64'd0,                 0, 64'd1,                 0,0,0, 64'd0,  8'h00,0,2);

    repeat (2) @(negedge clk);
    n_vec++;
    chk("reset.busy", {63'd0, busy}, 64'd0);
    chk("reset.done", {63'd0, done}, 64'd0);
    chk("reset.fault", {63'd0, fault}, 64'd0);
    chk("reset.mem_req", {63'd0, mem_req}, 64'd0);
    chk("reset.alu_sel", {56'd0, alu_sel}, 64'd0);
    chk("reset.rd_data", rd_data, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      n_vec++;
      mem_val = vt[i].mval; rd_err = vt[i].err; ack_dly = 0;
      run_op(vt[i].op, vt[i].size, vt[i].addr, vt[i].rs2, 0, 0, 20,
             lat, rd, flt, rq, raddr, wr, wd, sl, un, rq_cyc);
      msk = (vt[i].size == 4'b0100) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      chk($sformatf("v%0d.lat", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("v%0d.rd", i), rd, vt[i].rd);
      chk($sformatf("v%0d.fault", i), {63'd0, flt}, {63'd0, vt[i].flt});
      chk($sformatf("v%0d.rdreq", i), {63'd0, rq}, {63'd0, vt[i].rdreq});
      if (vt[i].rdreq) chk($sformatf("v%0d.raddr", i), raddr, vt[i].addr);
      chk($sformatf("v%0d.wr", i), {63'd0, wr}, {63'd0, vt[i].wr});
      if (vt[i].wr) chk($sformatf("v%0d.wdata", i), wd & msk, vt[i].wdata);
      chk($sformatf("v%0d.sel", i), {56'd0, sl}, {56'd0, vt[i].sel});
      chk($sformatf("v%0d.uns", i), {63'd0, un}, {63'd0, vt[i].uns});
    end
    rd_err = 1'b0;

    // LR.W, snoop to same granule while idle, then SC.W fails without touching memory.
    n_vec++;
    mem_val = 64'd5;
    run_op(4'd9, 4'b0100, 64'h3000, 64'd0, 0, 0, 20, lat, rd, flt, rq, raddr, wr, wd, sl, un, rq_cyc);
    chk("snoop.lr_rd", rd, 64'd5);
    @(negedge clk); snoop_inv = 1'b1; snoop_addr = 64'h3010;
    @(negedge clk); snoop_inv = 1'b0;
    run_op(4'd10, 4'b0100, 64'h3000, 64'd9, 0, 0, 20, lat, rd, flt, rq, raddr, wr, wd, sl, un, rq_cyc);
    chk("snoop.sc_rd", rd, 64'd1);
    chk("snoop.sc_req", 64'(rq_cyc), 64'd0);

    // Snoop coincident with the SC check cycle.
    n_vec++;
    run_op(4'd9, 4'b0100, 64'h3000, 64'd0, 0, 0, 20, lat, rd, flt, rq, raddr, wr, wd, sl, un, rq_cyc);
    run_op(4'd10, 4'b0100, 64'h3000, 64'd9, 0, 1, 20, lat, rd, flt, rq, raddr, wr, wd, sl, un, rq_cyc);
    chk("snoopchk.sc_rd", rd, 64'd1);
    chk("snoopchk.sc_wr", {63'd0, wr}, 64'd0);

    // Same pair without a snoop succeeds.
    n_vec++;
    run_op(4'd9, 4'b0100, 64'h3000, 64'd0, 0, 0, 20, lat, rd, flt, rq, raddr, wr, wd, sl, un, rq_cyc);
    run_op(4'd10, 4'b0100, 64'h3000, 64'h1_2345_6789, 0, 0, 20, lat, rd, flt, rq, raddr, wr, wd, sl, un, rq_cyc);
    chk("scok.rd", rd, 64'd0);
    chk("scok.wdata", wd & 64'hFFFF_FFFF, 64'h2345_6789);

    // Flush in RD with a slow memory: request held until ack, no completion.
    n_vec++;
    ack_dly = 2; mem_val = 64'd5;
    run_op(4'd1, 4'b1000, 64'h1000, 64'd3, 2, 0, 10, lat, rd, flt, rq, raddr, wr, wd, sl, un, rq_cyc);
    chk("flush.lat", 64'(lat), -64'sd1);
    chk("flush.req_cycles", 64'(rq_cyc), 64'd3);
    chk("flush.wr", {63'd0, wr}, 64'd0);
    chk("flush.busy", {63'd0, busy}, 64'd0);
    ack_dly = 0;

    // flush and amo_valid together in IDLE: not accepted.
    n_vec++;
    @(negedge clk); amo_valid = 1'b1; flush = 1'b1; amo_op = 4'd1; amo_size = 4'b1000;
    @(posedge clk); #1 amo_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idleflush.busy", {63'd0, busy}, 64'd0);

    // Async reset during the write phase.
    n_vec++;
    ack_dly = 2;
    @(negedge clk); amo_valid = 1'b1; amo_op = 4'd1; amo_size = 4'b1000;
    amo_addr = 64'h1000; amo_rs2 = 64'd3;
    @(posedge clk); #1 amo_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req && mem_wr) break;
    end
    chk("rst.in_wr", {63'd0, mem_wr}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst.mem_wr", {63'd0, mem_wr}, 64'd0);
    chk("rst.busy", {63'd0, busy}, 64'd0);
    chk("rst.wdata", mem_wdata, 64'd0);
    @(negedge clk); rst_n = 1'b1; ack_dly = 0;

    // Normal op after reset recovers.
    n_vec++;
    mem_val = 64'd10;
    run_op(4'd1, 4'b1000, 64'h1000, 64'd3, 0, 0, 20, lat, rd, flt, rq, raddr, wr, wd, sl, un, rq_cyc);
    chk("post.rd", rd, 64'd10);
    chk("post.wdata", wd, 64'd13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
